// File: rtl/or_activity_monitor.sv
// rtl/or_activity_monitor.sv - OR-reduction activity monitor with idle timeout
module or_activity_monitor #(
    parameter int N       = 4,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             clr,
    output logic             any_q,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] idle_cnt,
    output logic [CNT_W-1:0] active_cnt,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ACTIVE    = 2'b01,
        QUIET     = 2'b10,
        TIMED_OUT = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           st;
    logic             sample_nz;
    logic [CNT_W-1:0] idle_next;

    assign sample_nz = |in_data;
    assign idle_next = idle_cnt + 1'b1;
    assign state     = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            any_q      <= 1'b0;
            idle_cnt   <= '0;
            active_cnt <= '0;
            timeout    <= 1'b0;
        end else if (clr) begin
            st         <= IDLE;
            any_q      <= 1'b0;
            idle_cnt   <= '0;
            active_cnt <= '0;
            timeout    <= 1'b0;
        end else if (in_valid) begin
            any_q <= sample_nz;
            if (sample_nz) begin
                st       <= ACTIVE;
                idle_cnt <= '0;
                if (active_cnt != CNT_MAX)
                    active_cnt <= active_cnt + 1'b1;
            end else if (st != TIMED_OUT) begin
                // idle_cnt stays below TIMEOUT outside TIMED_OUT, so it saturates here
                idle_cnt <= idle_next;
                if (idle_next == TIMEOUT_V) begin
                    st      <= TIMED_OUT;
                    timeout <= 1'b1;
                end else begin
                    st <= QUIET;
                end
            end
        end
    end

endmodule

// File: tb/tb_or_activity_monitor.sv
// tb/tb_or_activity_monitor.sv - directed self-checking bench for or_activity_monitor
module tb_or_activity_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       clr;

    logic       a_any, b_any, c_any;
    logic [1:0] a_st, b_st, c_st;
    logic [7:0] a_idle, a_act, c_idle, c_act;
    logic [1:0] b_idle, b_act;
    logic       a_to, b_to, c_to;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    or_activity_monitor #(.N(4), .TIMEOUT(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .any_q(a_any), .state(a_st), .idle_cnt(a_idle), .active_cnt(a_act), .timeout(a_to)
    );

    or_activity_monitor #(.N(4), .TIMEOUT(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .any_q(b_any), .state(b_st), .idle_cnt(b_idle), .active_cnt(b_act), .timeout(b_to)
    );

    or_activity_monitor #(.N(4), .TIMEOUT(1), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
        .any_q(c_any), .state(c_st), .idle_cnt(c_idle), .active_cnt(c_act), .timeout(c_to)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic c);
        in_valid = v;
        in_data  = d;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    // any_q, state, idle_cnt, active_cnt, timeout of the TIMEOUT=3/CNT_W=8 instance
    task automatic chk_a(input string tag, input logic any, input logic [1:0] st,
                         input logic [7:0] idle, input logic [7:0] act, input logic to);
        chk({tag, ".any"},  32'(a_any),  32'(any));
        chk({tag, ".st"},   32'(a_st),   32'(st));
        chk({tag, ".idle"}, 32'(a_idle), 32'(idle));
        chk({tag, ".act"},  32'(a_act),  32'(act));
        chk({tag, ".to"},   32'(a_to),   32'(to));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hF;
        clr      = 1'b0;
        #1;
        chk_a("rst_async", 1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_a("rst_hold", 1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        step(1'b1, 4'b0000, 1'b0);
        chk_a("zero1", 1'b0, 2'b10, 8'd1, 8'd0, 1'b0);
        chk("c.st_t1",   32'(c_st),   32'd3);
        chk("c.idle_t1", 32'(c_idle), 32'd1);
        chk("c.to_t1",   32'(c_to),   32'd1);

        step(1'b1, 4'b1010, 1'b0);
        chk_a("nz_1010", 1'b1, 2'b01, 8'd0, 8'd1, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        chk_a("nz_1111", 1'b1, 2'b01, 8'd0, 8'd2, 1'b0);

        step(1'b1, 4'b0000, 1'b0);
        chk_a("z_run1", 1'b0, 2'b10, 8'd1, 8'd2, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        chk_a("z_run2", 1'b0, 2'b10, 8'd2, 8'd2, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        chk_a("z_run3", 1'b0, 2'b11, 8'd3, 8'd2, 1'b1);
        step(1'b1, 4'b0000, 1'b0);
        chk_a("z_run4", 1'b0, 2'b11, 8'd3, 8'd2, 1'b1);
        step(1'b1, 4'b0001, 1'b0);
        chk_a("wake", 1'b1, 2'b01, 8'd0, 8'd3, 1'b1);

        step(1'b0, 4'b0000, 1'b0);
        chk_a("novalid", 1'b1, 2'b01, 8'd0, 8'd3, 1'b1);

        step(1'b1, 4'b1000, 1'b1);
        chk_a("clr_prio", 1'b0, 2'b00, 8'd0, 8'd0, 1'b0);

        step(1'b1, 4'b0000, 1'b0);
        chk_a("tog1", 1'b0, 2'b10, 8'd1, 8'd0, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        chk_a("tog2", 1'b0, 2'b10, 8'd1, 8'd0, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        chk_a("tog3", 1'b0, 2'b10, 8'd2, 8'd0, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        chk_a("tog4", 1'b0, 2'b10, 8'd2, 8'd0, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        chk_a("tog5", 1'b0, 2'b11, 8'd3, 8'd0, 1'b1);

        step(1'b0, 4'b0000, 1'b1);
        chk("b.act_clr", 32'(b_act), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 4'(i), 1'b0);
            chk($sformatf("b.act_sat%0d", i), 32'(b_act), (i >= 3) ? 32'd3 : 32'(i));
            chk($sformatf("b.any_sat%0d", i), 32'(b_any), 32'd1);
        end
        chk("a.act_5", 32'(a_act), 32'd5);

        #2;
        rst_n = 1'b0;
        #1;
        chk_a("mid_rst", 1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
        chk("b.any_rst", 32'(b_any), 32'd0);
        chk("b.act_rst", 32'(b_act), 32'd0);
        chk("c.to_rst",  32'(c_to),  32'd0);
        step(1'b1, 4'b1111, 1'b0);
        chk_a("rst_ignore", 1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 4'b0000, 1'b0);
        chk_a("post_rst", 1'b0, 2'b10, 8'd1, 8'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
